// File: rtl/riscv_multi_ctrl.sv
// rtl/riscv_multi_ctrl.sv - multi-cycle RV32I control FSM
//
// Sequences the shared ALU, the unified memory port and the register file
// of the multi-cycle datapath, one instruction at a time.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   op, funct3, funct7b5     fields of the latched instruction register
//   zero, neg, ov            flags of the ALU's current combinational result
//   pc_we, adr_src, mem_we   PC write, address select (0 PC / 1 result), mem write
//   ir_we, reg_we            IR + old_pc latch, register-file write
//   alu_src_a, alu_src_b     ALU operand selects
//   alu_ctrl                 ALU operation code
//   res_src, imm_src         result-bus select, immediate format
//   illegal                  sticky unsupported-instruction flag
//   retired                  count of completed instructions (wraps)

module riscv_multi_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        neg,
    input  logic        ov,
    output logic        pc_we,
    output logic        adr_src,
    output logic        mem_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  res_src,
    output logic [1:0]  imm_src,
    output logic        illegal,
    output logic [31:0] retired
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_JAL_WB,
        S_HALT
    } state_t;

    state_t state;
    state_t nxt_state;

    // Low from reset until the first clock edge: state already reads FETCH
    // but no enable may fire before that edge.
    logic run;

    logic [3:0] arith_ctrl;
    logic       arith_ok;
    logic       branch_ok;
    logic       branch_taken;

    // ALU operation for EXEC_R / EXEC_I; only EXEC_R honours funct7b5.
    always_comb begin
        arith_ctrl = ALU_ADD;
        arith_ok   = 1'b1;
        case (funct3)
            3'b000:  arith_ctrl = (funct7b5 && state == S_EXEC_R) ? ALU_SUB : ALU_ADD;
            3'b010:  arith_ctrl = ALU_SLT;
            3'b110:  arith_ctrl = ALU_OR;
            3'b111:  arith_ctrl = ALU_AND;
            default: arith_ok   = 1'b0;
        endcase
    end

    // Branch resolution from the SUB flags of rs1 - rs2.
    always_comb begin
        branch_ok    = 1'b1;
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = neg ^ ov;
            3'b101:  branch_taken = !(neg ^ ov);
            default: branch_ok    = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state = S_HALT;
        case (state)
            S_FETCH:   nxt_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: nxt_state = S_MEM_ADR;
                    OP_R:         nxt_state = S_EXEC_R;
                    OP_I:         nxt_state = S_EXEC_I;
                    OP_BRANCH:    nxt_state = S_BRANCH;
                    OP_JAL:       nxt_state = S_JAL;
                    default:      nxt_state = S_HALT;
                endcase
            end
            S_MEM_ADR: nxt_state = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  nxt_state = S_MEM_WB;
            S_MEM_WB:  nxt_state = S_FETCH;
            S_MEM_WR:  nxt_state = S_FETCH;
            S_EXEC_R:  nxt_state = arith_ok ? S_ALU_WB : S_HALT;
            S_EXEC_I:  nxt_state = arith_ok ? S_ALU_WB : S_HALT;
            S_ALU_WB:  nxt_state = S_FETCH;
            S_BRANCH:  nxt_state = branch_ok ? S_FETCH : S_HALT;
            S_JAL:     nxt_state = S_JAL_WB;
            S_JAL_WB:  nxt_state = S_FETCH;
            S_HALT:    nxt_state = S_HALT;
            default:   nxt_state = S_HALT;
        endcase
    end

    // FETCH is only ever re-entered from a completing state, so a return to
    // FETCH marks a retired instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            illegal <= 1'b0;
            retired <= 32'd0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            state <= nxt_state;
            if (nxt_state == S_HALT)
                illegal <= 1'b1;
            if (nxt_state == S_FETCH)
                retired <= retired + 32'd1;
        end
    end

    // Moore decode of the registered state; BRANCH pc_we alone follows the flags.
    always_comb begin
        pc_we     = 1'b0;
        adr_src   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_ctrl  = ALU_ADD;
        res_src   = 2'b00;
        imm_src   = 2'b00;
        if (run) begin
            case (state)
                S_FETCH: begin
                    ir_we     = 1'b1;
                    alu_src_b = 2'b10;
                    res_src   = 2'b10;
                    pc_we     = 1'b1;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
                end
                S_MEM_ADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_LW) ? 2'b00 : 2'b01;
                end
                S_MEM_RD: begin
                    adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    res_src = 2'b01;
                    reg_we  = 1'b1;
                end
                S_MEM_WR: begin
                    adr_src = 1'b1;
                    mem_we  = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = arith_ctrl;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_ctrl  = arith_ctrl;
                end
                S_ALU_WB, S_JAL_WB: begin
                    reg_we = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = ALU_SUB;
                    pc_we     = branch_ok && branch_taken;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_we     = 1'b1;
                    reg_we    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multi_ctrl.sv
// tb/tb_riscv_multi_ctrl.sv - directed self-checking bench for riscv_multi_ctrl
module tb_riscv_multi_ctrl;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] ANDC = 4'b0010;
    localparam logic [3:0] ORC = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        neg = 1'b0;
    logic        ov_flag = 1'b0;
    logic        pc_we, adr_src, mem_we, ir_we, reg_we, illegal;
    logic [1:0]  alu_src_a, alu_src_b, res_src, imm_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail = 0;

    riscv_multi_ctrl dut (
        .clk(clk), .rst(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .ov(ov_flag),
        .pc_we(pc_we), .adr_src(adr_src), .mem_we(mem_we), .ir_we(ir_we),
        .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_ctrl(alu_ctrl), .res_src(res_src), .imm_src(imm_src),
        .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {pc_we, adr_src, mem_we, ir_we, reg_we, alu_src_a, alu_src_b,
                  alu_ctrl, res_src, imm_src, illegal};

    function automatic logic [18:0] mk(input logic pcw, input logic ar, input logic mw,
                                       input logic irw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] c, input logic [1:0] rs,
                                       input logic [1:0] im, input logic il);
        return {pcw, ar, mw, irw, rw, a, b, c, rs, im, il};
    endfunction

    function automatic logic [18:0] fetch_v();
        return mk(1, 0, 0, 1, 0, 2'b00, 2'b10, ADD, 2'b10, 2'b00, 0);
    endfunction

    function automatic logic [18:0] decode_v(input logic [1:0] im);
        return mk(0, 0, 0, 0, 0, 2'b01, 2'b01, ADD, 2'b00, im, 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++; $display("FAIL reset_outputs obs=%h exp=%h", obs, 19'd0);
        end
        n_checks++;
        if (retired !== 32'd0) begin
            n_fail++; $display("FAIL reset_retired obs=%0d exp=0", retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++; $display("FAIL post_release_idle obs=%h exp=%h", obs, 19'd0);
        end
        tick();
        n_checks++;
        if (obs !== fetch_v()) begin
            n_fail++; $display("FAIL first_fetch obs=%h exp=%h", obs, fetch_v());
        end
    endtask

    // Entry and exit: DUT sampled in FETCH.
    task automatic test_lw();
        logic [18:0] exp_v [5];
        logic [31:0] r0;
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        r0 = retired;
        exp_v[0] = fetch_v();
        exp_v[1] = decode_v(2'b10);
        exp_v[2] = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, ADD, 2'b00, 2'b00, 0);
        exp_v[3] = mk(0, 1, 0, 0, 0, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 0);
        exp_v[4] = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, ADD, 2'b01, 2'b00, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL lw_cycle%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
            end
        end
        tick();
        n_checks++;
        if (retired !== r0 + 32'd1) begin
            n_fail++; $display("FAIL lw_retired obs=%0d exp=%0d", retired, r0 + 32'd1);
        end
        n_checks++;
        if (obs !== fetch_v()) begin
            n_fail++; $display("FAIL lw_next_fetch obs=%h exp=%h", obs, fetch_v());
        end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic z, input logic n,
                               input logic o, input logic taken);
        logic [18:0] exp_v [3];
        logic [31:0] r0;
        op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0;
        zero = z; neg = n; ov_flag = o;
        r0 = retired;
        exp_v[0] = fetch_v();
        exp_v[1] = decode_v(2'b10);
        exp_v[2] = mk(taken, 0, 0, 0, 0, 2'b10, 2'b00, SUB, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL branch_f3_%0d_cycle%0d obs=%h exp=%h", f3, i + 1, obs, exp_v[i]);
            end
        end
        tick();
        n_checks++;
        if (retired !== r0 + 32'd1) begin
            n_fail++; $display("FAIL branch_retired obs=%0d exp=%0d", retired, r0 + 32'd1);
        end
        zero = 1'b0; neg = 1'b0; ov_flag = 1'b0;
    endtask

    task automatic test_arith(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [3:0] exp_ctrl, input logic [1:0] b_sel);
        logic [18:0] exp_v [4];
        logic [31:0] r0;
        op = opc; funct3 = f3; funct7b5 = f7;
        r0 = retired;
        exp_v[0] = fetch_v();
        exp_v[1] = decode_v(2'b10);
        exp_v[2] = mk(0, 0, 0, 0, 0, 2'b10, b_sel, exp_ctrl, 2'b00, 2'b00, 0);
        exp_v[3] = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++;
                $display("FAIL arith_op%h_f3_%0d_cycle%0d obs=%h exp=%h", opc, f3, i + 1, obs, exp_v[i]);
            end
        end
        tick();
        n_checks++;
        if (retired !== r0 + 32'd1) begin
            n_fail++; $display("FAIL arith_retired obs=%0d exp=%0d", retired, r0 + 32'd1);
        end
    endtask

    task automatic test_sw();
        logic [18:0] exp_v [4];
        logic [31:0] r0;
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        r0 = retired;
        exp_v[0] = fetch_v();
        exp_v[1] = decode_v(2'b10);
        exp_v[2] = mk(0, 0, 0, 0, 0, 2'b10, 2'b01, ADD, 2'b00, 2'b01, 0);
        exp_v[3] = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL sw_cycle%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
            end
        end
        tick();
        n_checks++;
        if (retired !== r0 + 32'd1) begin
            n_fail++; $display("FAIL sw_retired obs=%0d exp=%0d", retired, r0 + 32'd1);
        end
    endtask

    task automatic test_jal();
        logic [18:0] exp_v [4];
        logic [31:0] r0;
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        r0 = retired;
        exp_v[0] = fetch_v();
        exp_v[1] = decode_v(2'b11);
        exp_v[2] = mk(1, 0, 0, 0, 1, 2'b01, 2'b10, ADD, 2'b00, 2'b00, 0);
        exp_v[3] = mk(0, 0, 0, 0, 1, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (obs !== exp_v[i]) begin
                n_fail++; $display("FAIL jal_cycle%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
            end
        end
        tick();
        n_checks++;
        if (retired !== r0 + 32'd1) begin
            n_fail++; $display("FAIL jal_retired obs=%0d exp=%0d", retired, r0 + 32'd1);
        end
    endtask

    task automatic test_halt();
        logic [31:0] r0;
        op = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0;
        r0 = retired;
        tick();
        n_checks++;
        if (obs !== decode_v(2'b10)) begin
            n_fail++; $display("FAIL halt_decode obs=%h exp=%h", obs, decode_v(2'b10));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (obs !== mk(0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 1)) begin
                n_fail++; $display("FAIL halt_cycle%0d obs=%h exp=%h", i, obs,
                                   mk(0, 0, 0, 0, 0, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 1));
            end
        end
        n_checks++;
        if (retired !== r0) begin
            n_fail++; $display("FAIL halt_retired obs=%0d exp=%0d", retired, r0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (illegal !== 1'b0 || retired !== 32'd0) begin
            n_fail++; $display("FAIL halt_reset_clear illegal=%b retired=%0d exp 0/0", illegal, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs !== fetch_v()) begin
            n_fail++; $display("FAIL halt_restart_fetch obs=%h exp=%h", obs, fetch_v());
        end
    endtask

    task automatic test_abort();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (obs !== mk(0, 1, 0, 0, 0, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 0)) begin
            n_fail++; $display("FAIL abort_mem_rd obs=%h exp=%h", obs,
                               mk(0, 1, 0, 0, 0, 2'b00, 2'b00, ADD, 2'b00, 2'b00, 0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++; $display("FAIL abort_outputs obs=%h exp=%h", obs, 19'd0);
        end
        tick();
        n_checks++;
        if (obs !== 19'd0 || retired !== 32'd0) begin
            n_fail++; $display("FAIL abort_held obs=%h retired=%0d exp 0/0", obs, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs !== fetch_v()) begin
            n_fail++; $display("FAIL abort_restart_fetch obs=%h exp=%h", obs, fetch_v());
        end
        test_lw();
    endtask

    initial begin
        logic [31:0] instr;
        test_reset();
        test_lw();
        instr = 32'h00401863;
        test_branch(instr[14:12], 1'b0, 1'b0, 1'b0, 1'b1);
        test_branch(instr[14:12], 1'b1, 1'b0, 1'b0, 1'b0);
        test_branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
        test_branch(3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
        test_branch(3'b101, 1'b0, 1'b1, 1'b1, 1'b1);
        test_arith(7'b0110011, 3'b000, 1'b1, SUB, 2'b00);
        test_arith(7'b0110011, 3'b111, 1'b0, ANDC, 2'b00);
        test_arith(7'b0010011, 3'b000, 1'b1, ADD, 2'b01);
        test_arith(7'b0010011, 3'b110, 1'b0, ORC, 2'b01);
        test_sw();
        test_jal();
        n_checks++;
        if (retired !== 32'd12) begin
            n_fail++; $display("FAIL total_retired obs=%0d exp=12", retired);
        end
        test_halt();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout reached obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_multi_ctrl.md
# riscv_multi_ctrl

Control FSM for the multi-cycle RV32I core. It sequences a single shared ALU, one unified instruction/data memory port and the register file across several cycles per instruction. It decodes the latched instruction fields and drives every mux select and write enable of the multi-cycle datapath. It also resolves conditional branches from the ALU flags and counts retired instructions.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `op`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`, `neg`, `ov`  in  1 each  ALU flags of the current cycle's combinational result.
- `pc_we`  out  1  PC register write enable.
- `adr_src`  out  1  memory address: 0 = PC, 1 = result bus.
- `mem_we`  out  1  memory write enable.
- `ir_we`  out  1  latches instruction register and old_pc.
- `reg_we`  out  1  register-file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = old_pc, 10 = rs1 data.
- `alu_src_b`  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4.
- `alu_ctrl`  out  4  ALU op, encoded with the `alu.vh` codes (ADD, SUB, AND, OR, SLT).
- `res_src`  out  2  00 = alu_out register, 01 = mem data register, 10 = ALU direct.
- `imm_src`  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- `illegal`  out  1  sticky; set on an unsupported opcode.
- `retired`  out  32  count of completed instructions.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, HALT.
- FETCH: adr_src=0, ir_we=1, alu_src_a=00, alu_src_b=10, alu_ctrl=ADD, res_src=10, pc_we=1. This computes PC+4. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, alu_ctrl=ADD. This precomputes the branch target into alu_out. Next state by op:
  - 0000011 (lw) or 0100011 (sw) → MEM_ADR.
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - Anything else → HALT.
- MEM_ADR: alu_src_a=10, alu_src_b=01, ADD; imm_src=00 for lw, 01 for sw. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: adr_src=1, res_src=00 → MEM_WB.
- MEM_WB: res_src=01, reg_we=1 → FETCH.
- MEM_WR: adr_src=1, res_src=00, mem_we=1 → FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00. funct3 000 gives SUB if funct7b5 is set, else ADD. 010 → SLT, 110 → OR, 111 → AND. Other funct3 values → HALT. Otherwise next is ALU_WB.
- EXEC_I: same as EXEC_R with alu_src_b=01 and imm_src=00, except funct3 000 is always ADD.
- ALU_WB: res_src=00, reg_we=1 → FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, SUB, res_src=00. pc_we = taken, combinational on the flags:
  - beq (000): zero.
  - bne (001): !zero.
  - blt (100): neg^ov.
  - bge (101): !(neg^ov).
  - Other funct3 values → HALT with pc_we=0.
  - Otherwise next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, res_src=00, pc_we=1, reg_we=1. The write value is the JAL target computed in DECODE with imm_src=11; the ALU computes old_pc+4 for the next cycle. A JAL in flight occupies DECODE(imm J) → JAL → JAL_WB; JAL_WB is an ALU_WB alias with res_src=00. Next is FETCH.
- HALT: all enables 0, illegal=1. The FSM stays here until reset.
- retired increments by 1 on every transition into FETCH from a write-back, MEM_WR, BRANCH or JAL_WB state. It wraps from 0xFFFFFFFF to 0.
- Outputs not listed for a state are 0.

## Timing
- Reset (rst=0, asynchronous): state=FETCH, illegal=0, retired=0. All enables are low while rst=0.
- The first FETCH occurs on the first rising edge after rst deasserts.
- Latency in cycles: lw 5, sw 4, R/I 4, branch 3, jal 4.
- All outputs except BRANCH pc_we are Moore and decoded from registered state.
- Reset asserted mid-instruction aborts it immediately; no further writes occur and retired is not incremented.

## Test plan
- Reset then op=0000011 held → states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB.
  - reg_we=1 only in cycle 5.
  - retired=1 after cycle 5.
- Instruction 0x00401863 (bne, funct3=001) with zero=0 in BRANCH → pc_we=1 in cycle 3.
  - Same instruction with zero=1 → pc_we=0.
  - retired increments in both cases.
- op=0110011, funct3=000, funct7b5=1 → alu_ctrl=SUB in EXEC_R, reg_we in cycle 4.
- op=0100011 → mem_we=1 only in cycle 4, adr_src=1; reg_we never set.
- op=0000000 → HALT after DECODE, illegal=1, all enables 0 for 10 cycles.
  - rst pulse clears illegal and retired.
- rst asserted during MEM_RD → outputs clear immediately.
  - retired unchanged.
  - Next instruction starts at FETCH.
